// File: rtl/fifo_limites.sv
// rtl/fifo_limites.sv - synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error
module fifo_limites #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] fifo_data_in,
  input  logic                 fifo_write,
  input  logic                 fifo_read,
  input  logic [ADDR_BITS-1:0] high_limit,
  input  logic [ADDR_BITS-1:0] low_limit,
  output logic [DATA_BITS-1:0] fifo_data_out,
  output logic                 fifo_valid_out,
  output logic                 fifo_full_out,
  output logic                 fifo_empty_out,
  output logic                 almost_full_out,
  output logic                 almost_empty_out,
  output logic                 error_fifo_out
);

  localparam int DEPTH_WORDS = 1 << ADDR_BITS;
  // Occupancy is one bit wider than the pointers so "full" is distinguishable from "empty".
  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;

  logic rd_acc;
  logic wr_acc;
  logic err_now;

  // Acceptance and error decode; a full FIFO still takes a write when a read frees a slot on the same edge.
  always_comb begin
    rd_acc  = fifo_read && (count != '0);
    wr_acc  = fifo_write && ((count != DEPTH) || rd_acc);
    err_now = (fifo_write && (count == DEPTH) && !rd_acc) ||
              (fifo_read && (count == '0));
  end

  // Storage array; not reset, stale words are unreachable because count restarts at 0.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  // Pointers, occupancy, read data, valid strobe and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_data_out  <= '0;
      fifo_valid_out <= 1'b0;
      error_fifo_out <= 1'b0;
    end else begin
      fifo_valid_out <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (rd_acc) begin
        fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + ADDR_BITS'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + (ADDR_BITS+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - (ADDR_BITS+1)'(1);
      end
      if (err_now) begin
        error_fifo_out <= 1'b1;
      end
    end
  end

  // Status flags decode only the registered count and the live thresholds.
  always_comb begin
    fifo_full_out    = (count == DEPTH);
    fifo_empty_out   = (count == '0);
    almost_full_out  = (count >= {1'b0, high_limit});
    almost_empty_out = (count <= {1'b0, low_limit});
  end

endmodule

// File: doc/fifo_limites.md
FIFO_LIMITES -- requirements
Module: fifo_limites

Interface
REQ-001 Parameter DATA_BITS, default 10: width of each data word.
REQ-002 Parameter ADDR_BITS, default 3: pointer width; depth is 2^ADDR_BITS words (8 by default).
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: reset is asynchronous and active-low; 0 = reset asserted, 1 = operating.
REQ-005 fifo_data_in  input  DATA_BITS: write data, sampled on a rising edge when the write is accepted.
REQ-006 fifo_write  input  1: write request.
REQ-007 fifo_read  input  1: read request.
REQ-008 high_limit  input  ADDR_BITS: almost-full threshold, sampled continuously, not latched.
REQ-009 low_limit  input  ADDR_BITS: almost-empty threshold, sampled continuously, not latched.
REQ-010 fifo_data_out  output  DATA_BITS: registered read data.
REQ-011 fifo_valid_out  output  1: registered; high for one cycle after each accepted read.
REQ-012 fifo_full_out  output  1: occupancy equals depth.
REQ-013 fifo_empty_out  output  1: occupancy equals 0.
REQ-014 almost_full_out  output  1: occupancy >= high_limit.
REQ-015 almost_empty_out  output  1: occupancy <= low_limit.
REQ-016 error_fifo_out  output  1: sticky overflow/underflow indication.

Function
REQ-017 State: memory of 2^ADDR_BITS x DATA_BITS; write pointer and read pointer, each ADDR_BITS wide; occupancy count, ADDR_BITS+1 wide (0..depth).
REQ-018 Pointers wrap modulo 2^ADDR_BITS with no special handling (7 -> 0 at default size).
REQ-019 Read accepted = fifo_read AND count != 0.
REQ-020 Write accepted = fifo_write AND (count != depth OR read accepted).
REQ-021 Accepted write: store data at write pointer, then increment write pointer.
REQ-022 Accepted read: load fifo_data_out with the word at read pointer on the same edge, then increment read pointer; read-to-data latency is one clock.
REQ-023 With no accepted read, fifo_data_out holds its previous value.
REQ-024 fifo_valid_out is set on the edge of an accepted read and cleared on the next edge without one.
REQ-025 Count update: +1 on write only; -1 on read only; unchanged on both or neither.
REQ-026 Full with read and write both requested: both accepted, count stays at depth, fifo_full_out stays 1, no error; sustains indefinitely.
REQ-027 Empty with read and write both requested: write accepted, read rejected, count becomes 1, error set.
REQ-028 Error set condition: (fifo_write AND count == depth AND no accepted read) OR (fifo_read AND count == 0).
REQ-029 A rejected access does not modify the memory, pointers, count, or fifo_data_out.
REQ-030 error_fifo_out, once set, remains 1 until reset.
REQ-031 Flag outputs are combinational decodes of the registered count; they reflect the count after each edge and never depend combinationally on fifo_write or fifo_read.
REQ-032 Threshold comparisons zero-extend the limits to ADDR_BITS+1; high_limit = 0 forces almost_full_out = 1.

Reset
REQ-033 Asserting reset (reset = 0) immediately clears the pointers, count, fifo_data_out, fifo_valid_out, and error_fifo_out to 0, independent of clk.
REQ-034 During reset: fifo_empty_out = 1, fifo_full_out = 0, almost_empty_out = 1, and almost_full_out = 1 only if high_limit = 0.
REQ-035 Memory contents are not reset; reading data written before a reset is impossible because count = 0.
REQ-036 Reset asserted mid-operation discards all queued words; the first edge after deassertion behaves as from empty.
REQ-037 Requests present while reset = 0 are ignored.

Verification
REQ-038 Fill: reset, then 8 writes of 0x001..0x008 -> fifo_full_out = 1 after the 8th edge, almost_full_out asserted from count 6 (high_limit = 6), error_fifo_out = 0.
REQ-039 Overflow: full, then one write with read = 0 -> error_fifo_out = 1 and sticky, count stays 8, the following reads return 0x001..0x008 in order.
REQ-040 Constant full: full, then 20 cycles of write + read with random data -> fifo_full_out held at 1, fifo_valid_out = 1 each cycle, data out in write order, error_fifo_out = 0.
REQ-041 Underflow: empty, read = 1 -> error_fifo_out = 1, fifo_data_out unchanged, fifo_valid_out = 0; simultaneous write on empty -> count = 1.
REQ-042 Wrap: 12 writes interleaved with 12 reads, occupancy at most 3 -> output sequence matches input exactly; almost_empty_out follows count <= low_limit (2).
REQ-043 Mid-operation reset: count 5, pulse reset = 0 between edges -> outputs clear immediately, fifo_empty_out = 1, the next write/read pair returns the new word.
